// File: rtl/axi_outstanding_limiter_if.sv
// Soft-register request/response types and the AXI bus interface shared by the
// outstanding-burst limiter and its neighbours.
package axi_outstanding_limiter_pkg;
  typedef struct packed {
    logic        valid;
    logic        isWrite;
    logic [31:0] addr;
    logic [63:0] data;
  } SoftRegReq;

  typedef struct packed {
    logic        valid;
    logic [63:0] data;
  } SoftRegResp;
endpackage

interface axi_bus_t #(
  parameter int ID_W   = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic                arvalid;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arvalid, rready,
    input  awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awvalid, wdata, wstrb, wlast, wvalid, bready,
           arid, araddr, arlen, arsize, arvalid, rready,
    output awready, wready, bid, bresp, bvalid, arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_outstanding_limiter.sv
// Caps in-flight AXI read and write bursts per application; limits, live counts
// and stall statistics are exposed on the soft-register port.
module axi_outstanding_limiter
  import axi_outstanding_limiter_pkg::*;
#(
  parameter logic [31:0] SR_ADDR       = 32'h28,
  parameter int          CNT_W         = 8,
  parameter int          RD_LIMIT_INIT = 32,
  parameter int          WR_LIMIT_INIT = 32,
  parameter int          STALL_W       = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  SoftRegReq  sr_req,
  output SoftRegResp sr_resp,
  axi_bus_t.slave    axi_s,
  axi_bus_t.master   axi_m
);

  localparam logic [31:0] A_RD_LIM   = SR_ADDR;
  localparam logic [31:0] A_WR_LIM   = SR_ADDR + 32'd8;
  localparam logic [31:0] A_STATUS   = SR_ADDR + 32'd16;
  localparam logic [31:0] A_RD_STALL = SR_ADDR + 32'd24;
  localparam logic [31:0] A_WR_STALL = SR_ADDR + 32'd32;

  logic [CNT_W-1:0]   rd_cnt, wr_cnt, rd_lim, wr_lim;
  logic [STALL_W-1:0] rd_stall, wr_stall;
  logic               err_underflow;
  logic               rd_ok, wr_ok;
  logic               ar_hs, r_done, aw_hs, b_done;
  logic               sr_wr, rd_hit;
  logic [63:0]        rd_data;
  logic               resp_vld_p1;
  logic [63:0]        resp_data_p1;
  logic               unused_sr_hi;

  function automatic logic [CNT_W-1:0] cnt_next(logic [CNT_W-1:0] cnt, logic inc, logic dec);
    cnt_next = cnt;
    if (inc && !dec)
      cnt_next = cnt + 1'b1;
    else if (dec && !inc && cnt != '0)
      cnt_next = cnt - 1'b1;
  endfunction

  function automatic logic underflows(logic [CNT_W-1:0] cnt, logic inc, logic dec);
    return dec && !inc && (cnt == '0);
  endfunction

  function automatic logic [STALL_W-1:0] stall_inc(logic [STALL_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // A saturated counter gates issue even when the limit is 0 (unlimited).
  assign rd_ok = (rd_cnt != '1) && ((rd_lim == '0) || (rd_cnt < rd_lim));
  assign wr_ok = (wr_cnt != '1) && ((wr_lim == '0) || (wr_cnt < wr_lim));

  assign axi_m.arvalid = axi_s.arvalid & rd_ok;
  assign axi_s.arready = axi_m.arready & rd_ok;
  assign axi_m.awvalid = axi_s.awvalid & wr_ok;
  assign axi_s.awready = axi_m.awready & wr_ok;

  assign axi_m.arid   = axi_s.arid;
  assign axi_m.araddr = axi_s.araddr;
  assign axi_m.arlen  = axi_s.arlen;
  assign axi_m.arsize = axi_s.arsize;
  assign axi_m.awid   = axi_s.awid;
  assign axi_m.awaddr = axi_s.awaddr;
  assign axi_m.awlen  = axi_s.awlen;
  assign axi_m.awsize = axi_s.awsize;
  assign axi_m.wdata  = axi_s.wdata;
  assign axi_m.wstrb  = axi_s.wstrb;
  assign axi_m.wlast  = axi_s.wlast;
  assign axi_m.wvalid = axi_s.wvalid;
  assign axi_s.wready = axi_m.wready;
  assign axi_s.bid    = axi_m.bid;
  assign axi_s.bresp  = axi_m.bresp;
  assign axi_s.bvalid = axi_m.bvalid;
  assign axi_m.bready = axi_s.bready;
  assign axi_s.rid    = axi_m.rid;
  assign axi_s.rdata  = axi_m.rdata;
  assign axi_s.rresp  = axi_m.rresp;
  assign axi_s.rlast  = axi_m.rlast;
  assign axi_s.rvalid = axi_m.rvalid;
  assign axi_m.rready = axi_s.rready;

  assign ar_hs  = axi_s.arvalid & axi_m.arready & rd_ok;
  assign r_done = axi_m.rvalid & axi_s.rready & axi_m.rlast;
  assign aw_hs  = axi_s.awvalid & axi_m.awready & wr_ok;
  assign b_done = axi_m.bvalid & axi_s.bready;

  assign sr_wr        = sr_req.valid & sr_req.isWrite;
  assign unused_sr_hi = ^sr_req.data[63:CNT_W];

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (sr_req.valid && !sr_req.isWrite) begin
      case (sr_req.addr)
        A_RD_LIM:   begin rd_hit = 1'b1; rd_data = 64'(rd_lim); end
        A_WR_LIM:   begin rd_hit = 1'b1; rd_data = 64'(wr_lim); end
        A_STATUS:   begin rd_hit = 1'b1; rd_data = 64'({err_underflow, rd_cnt, wr_cnt}); end
        A_RD_STALL: begin rd_hit = 1'b1; rd_data = 64'(rd_stall); end
        A_WR_STALL: begin rd_hit = 1'b1; rd_data = 64'(wr_stall); end
        default:    ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      rd_lim        <= CNT_W'(RD_LIMIT_INIT);
      wr_lim        <= CNT_W'(WR_LIMIT_INIT);
      rd_stall      <= '0;
      wr_stall      <= '0;
      err_underflow <= 1'b0;
    end else begin
      rd_cnt <= cnt_next(rd_cnt, ar_hs, r_done);
      wr_cnt <= cnt_next(wr_cnt, aw_hs, b_done);
      if (underflows(rd_cnt, ar_hs, r_done) || underflows(wr_cnt, aw_hs, b_done))
        err_underflow <= 1'b1;
      if (sr_wr && sr_req.addr == A_RD_LIM) rd_lim <= sr_req.data[CNT_W-1:0];
      if (sr_wr && sr_req.addr == A_WR_LIM) wr_lim <= sr_req.data[CNT_W-1:0];
      // A clear in the same cycle as a stall wins over the increment.
      if (sr_wr && sr_req.addr == A_STATUS) begin
        rd_stall <= '0;
        wr_stall <= '0;
      end else begin
        if (axi_s.arvalid && !rd_ok) rd_stall <= stall_inc(rd_stall);
        if (axi_s.awvalid && !wr_ok) wr_stall <= stall_inc(wr_stall);
      end
    end
  end

  // Stage p1: registered soft-register read response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_vld_p1  <= 1'b0;
      resp_data_p1 <= '0;
    end else begin
      resp_vld_p1  <= rd_hit;
      resp_data_p1 <= rd_data;
    end
  end

  assign sr_resp.valid = resp_vld_p1;
  assign sr_resp.data  = resp_data_p1;

endmodule

// File: tb/tb_axi_outstanding_limiter.sv
// Directed and randomized bench for axi_outstanding_limiter against an
// arithmetic model of in-flight counts, limits and stall statistics.
module tb_axi_outstanding_limiter;
  import axi_outstanding_limiter_pkg::*;

  localparam logic [31:0] SR = 32'h28;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  SoftRegReq  sr_req;
  SoftRegResp sr_resp;
  axi_bus_t s_if ();
  axi_bus_t m_if ();

  axi_outstanding_limiter #(
    .SR_ADDR(SR), .CNT_W(8), .RD_LIMIT_INIT(32), .WR_LIMIT_INIT(32), .STALL_W(32)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sr_req(sr_req), .sr_resp(sr_resp),
    .axi_s(s_if), .axi_m(m_if)
  );

  int checks = 0;
  int failures = 0;

  // Model: bursts in flight, limits, stall totals, sticky underflow flag.
  int     m_rd_cnt, m_wr_cnt, m_rd_lim, m_wr_lim;
  longint m_rd_stall, m_wr_stall;
  bit     m_err;
  logic [63:0] last_rsp;
  logic        last_m_arvalid, last_m_awvalid;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_rd_cnt = 0; m_wr_cnt = 0; m_rd_lim = 32; m_wr_lim = 32;
    m_rd_stall = 0; m_wr_stall = 0; m_err = 0;
  endtask

  // An 8-bit count can hold at most 255 bursts, so "unlimited" means 255.
  function automatic int room(int lim);
    return (lim == 0) ? 255 : lim;
  endfunction

  function automatic logic [63:0] sr_value(longint off);
    case (off)
      0:  return 64'(m_rd_lim);
      8:  return 64'(m_wr_lim);
      16: return 64'(m_err) * 65536 + 64'(m_rd_cnt) * 256 + 64'(m_wr_cnt);
      24: return 64'(m_rd_stall);
      default: return 64'(m_wr_stall);
    endcase
  endfunction

  task automatic cycle();
    bit rok, wok, ar_hs, aw_hs, r_end, b_end, rsp_exp;
    logic [63:0] rsp_data;
    longint off;
    @(negedge clk);
    rok = m_rd_cnt < room(m_rd_lim);
    wok = m_wr_cnt < room(m_wr_lim);
    last_m_arvalid = m_if.arvalid;
    last_m_awvalid = m_if.awvalid;
    chk("m_arvalid", m_if.arvalid, s_if.arvalid & rok);
    chk("s_arready", s_if.arready, m_if.arready & rok);
    chk("m_awvalid", m_if.awvalid, s_if.awvalid & wok);
    chk("s_awready", s_if.awready, m_if.awready & wok);
    chk("araddr", m_if.araddr, s_if.araddr);
    chk("awlen", m_if.awlen, s_if.awlen);
    chk("wdata", m_if.wdata, s_if.wdata);
    chk("wvalid", m_if.wvalid, s_if.wvalid);
    chk("rdata", s_if.rdata, m_if.rdata);
    chk("rvalid", s_if.rvalid, m_if.rvalid);
    chk("rlast", s_if.rlast, m_if.rlast);
    chk("bvalid", s_if.bvalid, m_if.bvalid);
    chk("bready", m_if.bready, s_if.bready);

    ar_hs = s_if.arvalid & m_if.arready & rok;
    aw_hs = s_if.awvalid & m_if.awready & wok;
    r_end = m_if.rvalid & s_if.rready & m_if.rlast;
    b_end = m_if.bvalid & s_if.bready;

    off = longint'(sr_req.addr) - longint'(SR);
    rsp_exp = sr_req.valid && !sr_req.isWrite && off >= 0 && off <= 32 && (off % 8) == 0;
    rsp_data = rsp_exp ? sr_value(off) : 64'd0;

    if (s_if.arvalid && !rok && m_rd_stall < 64'hFFFF_FFFF) m_rd_stall++;
    if (s_if.awvalid && !wok && m_wr_stall < 64'hFFFF_FFFF) m_wr_stall++;

    if (ar_hs && !r_end) m_rd_cnt++;
    else if (r_end && !ar_hs) begin
      if (m_rd_cnt == 0) m_err = 1; else m_rd_cnt--;
    end
    if (aw_hs && !b_end) m_wr_cnt++;
    else if (b_end && !aw_hs) begin
      if (m_wr_cnt == 0) m_err = 1; else m_wr_cnt--;
    end

    if (sr_req.valid && sr_req.isWrite) begin
      if (off == 0)  m_rd_lim = int'(sr_req.data[7:0]);
      if (off == 8)  m_wr_lim = int'(sr_req.data[7:0]);
      if (off == 16) begin m_rd_stall = 0; m_wr_stall = 0; end
    end

    @(posedge clk);
    #1;
    chk("sr_resp_valid", sr_resp.valid, rsp_exp);
    if (rsp_exp) chk("sr_resp_data", sr_resp.data, rsp_data);
    last_rsp = sr_resp.data;
  endtask

  task automatic sr_write(input int off, input logic [63:0] data);
    sr_req = '{valid: 1'b1, isWrite: 1'b1, addr: SR + 32'(off), data: data};
    cycle();
    sr_req = '0;
  endtask

  task automatic sr_read(input int off);
    sr_req = '{valid: 1'b1, isWrite: 1'b0, addr: SR + 32'(off), data: {$urandom(), $urandom()}};
    cycle();
    sr_req = '0;
  endtask

  task automatic rand_payload();
    s_if.awid = 4'($urandom()); s_if.awaddr = $urandom(); s_if.awlen = 8'($urandom());
    s_if.awsize = 3'($urandom()); s_if.wdata = {$urandom(), $urandom()};
    s_if.wstrb = 8'($urandom()); s_if.wlast = 1'($urandom());
    s_if.arid = 4'($urandom()); s_if.araddr = $urandom(); s_if.arlen = 8'($urandom());
    s_if.arsize = 3'($urandom());
    m_if.bid = 4'($urandom()); m_if.bresp = 2'($urandom());
    m_if.rid = 4'($urandom()); m_if.rdata = {$urandom(), $urandom()}; m_if.rresp = 2'($urandom());
  endtask

  task automatic idle_handshakes();
    s_if.arvalid = 0; s_if.awvalid = 0; s_if.wvalid = 0; s_if.bready = 1; s_if.rready = 1;
    m_if.arready = 1; m_if.awready = 1; m_if.wready = 1;
    m_if.rvalid = 0; m_if.rlast = 0; m_if.bvalid = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    sr_req = '0;
    rand_payload();
    idle_handshakes();
    model_reset();
    last_rsp = '0;

    // Reset state: no response, gate open under zero counts.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_resp_valid", sr_resp.valid, 1'b0);
    chk("rst_resp_data", sr_resp.data, 64'd0);
    s_if.arvalid = 1;
    #1;
    chk("rst_ar_pass", m_if.arvalid, 1'b1);
    chk("rst_arready", s_if.arready, 1'b1);
    s_if.arvalid = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Read throttle at rd_lim=4.
    sr_write(0, 64'd4);
    s_if.arvalid = 1;
    repeat (6) cycle();
    chk("rd_throttle_gate", last_m_arvalid, 1'b0);
    s_if.arvalid = 0;
    sr_read(24);
    chk("rd_stall_two", last_rsp, 64'd2);
    sr_read(16);
    chk("rd_cnt_four", last_rsp, 64'h400);
    s_if.arvalid = 1; m_if.rvalid = 1; m_if.rlast = 1;
    cycle();
    chk("rd_gate_while_rlast", last_m_arvalid, 1'b0);
    m_if.rvalid = 0; m_if.rlast = 0;
    cycle();
    chk("rd_fifth_passes", last_m_arvalid, 1'b1);
    s_if.arvalid = 0;

    // Simultaneous increment and decrement.
    m_if.rvalid = 1; m_if.rlast = 1;
    cycle();
    s_if.arvalid = 1;
    cycle();
    s_if.arvalid = 0; m_if.rvalid = 0; m_if.rlast = 0;
    sr_read(16);
    chk("rd_simul_hold", last_rsp, 64'h300);
    s_if.awvalid = 1;
    repeat (3) cycle();
    m_if.bvalid = 1;
    cycle();
    s_if.awvalid = 0; m_if.bvalid = 0;
    sr_read(16);
    chk("wr_simul_hold", last_rsp, 64'h303);

    // Soft-register readback and unmatched address.
    sr_write(8, {32'hDEAD_BEEF, 32'h0000_0707});
    sr_read(8);
    chk("wr_lim_readback", last_rsp, 64'd7);
    cycle();
    sr_read(40);
    chk("bad_addr_noresp", sr_resp.valid, 1'b0);

    // Drain writes, then one B with nothing outstanding.
    m_if.bvalid = 1;
    repeat (4) cycle();
    m_if.bvalid = 0;
    sr_read(16);
    chk("underflow_sticky", last_rsp, 64'h10300);

    // Lowering a limit below the current count.
    sr_write(0, 64'd16);
    s_if.arvalid = 1;
    repeat (7) cycle();
    s_if.arvalid = 0;
    sr_write(0, 64'd2);
    s_if.arvalid = 1;
    for (int i = 0; i < 9; i++) begin
      m_if.rvalid = 1; m_if.rlast = 0;
      cycle();
      chk("lowered_gate_beat", last_m_arvalid, 1'b0);
      m_if.rlast = 1;
      cycle();
      chk("lowered_gate_last", last_m_arvalid, 1'b0);
    end
    m_if.rvalid = 0; m_if.rlast = 0;
    cycle();
    chk("lowered_reopen", last_m_arvalid, 1'b1);
    cycle();
    chk("lowered_regate", last_m_arvalid, 1'b0);
    s_if.arvalid = 0;
    sr_read(16);
    chk("lowered_count", last_rsp, 64'h10200);

    // Unlimited writes saturate at 255.
    sr_write(8, 64'd0);
    s_if.awvalid = 1;
    repeat (255) cycle();
    cycle();
    chk("wr_sat_gate", last_m_awvalid, 1'b0);
    s_if.awvalid = 0;
    sr_read(16);
    chk("wr_sat_count", last_rsp, 64'h102FF);
    s_if.awvalid = 1; m_if.bvalid = 1;
    cycle();
    chk("wr_sat_gate_b", last_m_awvalid, 1'b0);
    m_if.bvalid = 0;
    cycle();
    chk("wr_sat_reopen", last_m_awvalid, 1'b1);
    s_if.awvalid = 0;

    // Randomized traffic, limits and register accesses.
    for (int i = 0; i < 3000; i++) begin
      rand_payload();
      s_if.arvalid = 1'($urandom()); s_if.awvalid = 1'($urandom());
      s_if.wvalid = 1'($urandom()); s_if.rready = 1'($urandom()); s_if.bready = 1'($urandom());
      m_if.arready = 1'($urandom()); m_if.awready = 1'($urandom()); m_if.wready = 1'($urandom());
      m_if.rvalid = 1'($urandom()); m_if.rlast = ($urandom_range(0, 2) == 0);
      m_if.bvalid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        sr_req.valid = 1'b1;
        sr_req.isWrite = ($urandom_range(0, 2) == 0);
        sr_req.addr = ($urandom_range(0, 7) == 0) ? $urandom() : SR + 32'($urandom_range(0, 6) * 8) - 32'd8;
        sr_req.data = {$urandom(), $urandom()};
        sr_req.data[7:0] = 8'($urandom_range(0, 6));
      end else begin
        sr_req = '0;
      end
      cycle();
    end
    sr_req = '0;
    idle_handshakes();

    // Asynchronous reset in the middle of traffic.
    sr_write(0, 64'd1);
    s_if.arvalid = 1;
    cycle();
    sr_req = '{valid: 1'b1, isWrite: 1'b0, addr: SR, data: 64'd0};
    cycle();
    sr_req = '0;
    chk("pre_rst_gate", m_if.arvalid, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", sr_resp.valid, 1'b0);
    chk("async_rst_data", sr_resp.data, 64'd0);
    chk("async_rst_gate_open", m_if.arvalid, 1'b1);
    model_reset();
    s_if.arvalid = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    sr_read(0);
    chk("post_rst_rd_lim", last_rsp, 64'd32);
    sr_read(8);
    chk("post_rst_wr_lim", last_rsp, 64'd32);
    sr_read(16);
    chk("post_rst_status", last_rsp, 64'd0);
    sr_read(24);
    chk("post_rst_rd_stall", last_rsp, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_outstanding_limiter.md
Name: axi_outstanding_limiter

Overview:
- Per-application AXI throttle. Sits directly upstream of each application's first input register slice, between the application master bus and the address-translation path into the DDR crossbar.
- Caps the number of in-flight read bursts and write bursts each application may hold, so one application cannot monopolise the shared DDR crossbar queues.
- Limits are programmable through the application's soft-register port. Live outstanding counts and stall statistics are readable back through the same port.

Parameters:
- SR_ADDR, 'h28, soft-register base address. SR_ADDR+0 is the read limit, SR_ADDR+8 the write limit, SR_ADDR+16 the stall-counter clear.
- CNT_W, 8, width of outstanding counters and limit registers.
- RD_LIMIT_INIT, 32, read limit at reset.
- WR_LIMIT_INIT, 32, write limit at reset.
- STALL_W, 32, width of the stall cycle counters.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  asynchronous, active-low reset.
- sr_req  in  SoftRegReq  soft-register request: valid, isWrite, addr, data.
- sr_resp  out  SoftRegResp  soft-register read response: valid, data.
- axi_s  axi_bus_t.slave  intf  from the application master.
- axi_m  axi_bus_t.master  intf  toward the register slice / TLB path.

Behaviour:
- Pass-through channels:
  - All AXI payload fields (id, addr, len, size, data, strb, last, resp) pass through combinationally, zero added latency.
  - W, R and B valid/ready are never gated.
- Read gate:
  - rd_ok = (rd_lim == 0) || (rd_cnt < rd_lim).
  - axi_m.arvalid = axi_s.arvalid & rd_ok.
  - axi_s.arready = axi_m.arready & rd_ok.
- Write gate: wr_ok, awvalid and awready are formed identically from wr_cnt and wr_lim.
- Limit value 0 means unlimited. Counters still track, saturating at 2^CNT_W-1. At saturation AR/AW are gated regardless of the limit, so the counter never wraps.
- Read counter:
  - rd_cnt +1 on an AR handshake at axi_m.
  - rd_cnt −1 on an R handshake with rlast.
  - Both in the same cycle: no change.
  - A decrement at 0 is an illegal protocol event: counter holds at 0, sticky bit err_underflow is set.
- Write counter:
  - wr_cnt +1 on an AW handshake.
  - wr_cnt −1 on a B handshake.
  - Simultaneous events and underflow handled as for reads.
- Limit changes:
  - Take effect the cycle after the sr write.
  - Lowering a limit below the current count blocks new issue until the count drains below it. Nothing in flight is dropped.
- Stall counters:
  - rd_stall +1 each cycle with axi_s.arvalid & !rd_ok.
  - wr_stall likewise for AW.
  - Both saturate at all-ones.
  - Cleared by a write to SR_ADDR+16, any data.
- Soft-register writes: sr_req.valid & isWrite at a matching address updates the register next edge. The low CNT_W bits of data are used; upper bits are ignored.
- Soft-register reads: sr_req.valid & !isWrite at a matching address gives sr_resp.valid = 1 exactly one cycle later. Read data by offset:
  - +0: rd_lim.
  - +8: wr_lim.
  - +16: {err_underflow, rd_cnt, wr_cnt}, zero-extended to 64 bits.
  - +24: rd_stall.
  - +32: wr_stall.
- Non-matching addresses: no response; sr_resp.valid stays 0.
- Reset state (async assert, sync deassert assumed at top level):
  - rd_cnt = wr_cnt = 0.
  - rd_lim = RD_LIMIT_INIT, wr_lim = WR_LIMIT_INIT.
  - Stall counters and err_underflow = 0.
  - sr_resp.valid = 0, sr_resp.data = 0.
  - AXI outputs follow their inputs combinationally under the reset counter values.
- Reset mid-transaction: counters clear. The limiter does not track responses for pre-reset bursts; downstream is reset by the same rst_n.

Test Plan:
- Read throttle: rd_lim=4, issue 6 back-to-back single-beat ARs with arready=1 and R held off → 4 ARs pass; arvalid on axi_m stays 0 for the 5th; rd_stall increments each blocked cycle. Return 1 rlast → 5th AR passes the next cycle.
- Simultaneous events: rd_cnt=3, AR handshake and R rlast handshake in the same cycle → rd_cnt stays 3. Same check for AW plus B on wr_cnt.
- Unlimited and saturation: wr_lim=0, CNT_W=8, 255 AWs with no B → wr_cnt=255 and the 256th AW is gated. One B → gate opens.
- Limit lowered: rd_cnt=10, write rd_lim=2 → no AR passes until rd_cnt drops to 1. In-flight R beats are unaffected.
- Softreg readback: write 7 to SR_ADDR+8, then read SR_ADDR+8 → sr_resp.valid=1 exactly one cycle after the request, data=7. Read address SR_ADDR+40 → no response.
- Reset and underflow: B handshake with wr_cnt=0 → wr_cnt stays 0 and err_underflow reads 1. Assert rst_n low mid-burst → all counters 0 and the limits return to 32 asynchronously.
